// File: rtl/pci_arbiter_if.sv
// Bus-side signal bundle for the PCI arbiter: request/grant lines plus the observed FRAME#/IRDY#.
// The master modport is the arbiter's view. The slave modport is the requester/bus-model view.
interface pci_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] req_n;
    logic                   frame_n;
    logic                   irdy_n;
    logic [NUM_MASTERS-1:0] gnt_n;
    logic [OW-1:0]          owner;
    logic                   owner_valid;
    logic                   timeout;

    modport master (
        input  req_n, frame_n, irdy_n,
        output gnt_n, owner, owner_valid, timeout
    );

    modport slave (
        output req_n, frame_n, irdy_n,
        input  gnt_n, owner, owner_valid, timeout
    );
endinterface

// File: rtl/pci_arbiter.sv
// Central round-robin PCI arbiter with hidden arbitration, idle-bus grant gap and grant timeout.
// Define PCI_ARB_PARK_EN to park the grant on the last owner when no master is requesting.
//
// state    | meaning
// NOGNT    | no grant, waiting for a request
// GRANT    | owner granted, bus idle, idle counter running
// BUSY     | transaction in progress, grant may move (hidden arbitration)
// GAP      | one-cycle all-grants-high turnaround on an idle bus
// PARK     | grant parked on last owner with nothing requested (parking builds only)
module pci_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic            clk,
    input  logic            rst,
    pci_arbiter_if.master   bus
);
    localparam int OW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        ST_NOGNT,
        ST_GRANT,
        ST_BUSY,
        ST_GAP,
        ST_PARK
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_n_q, gnt_n_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic                   owner_valid_q, owner_valid_d;
    logic                   timeout_q, timeout_d;
    logic [OW-1:0]          last_q, last_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] own_oh;
    logic                   bus_idle;
    logic                   owner_req;
    logic [OW:0]            win_any;
    logic [OW:0]            win_oth;

    // Returns {found, index} of the first requester after 'from', wrapping around.
    function automatic logic [OW:0] rr_pick(input logic [NUM_MASTERS-1:0] r,
                                            input logic [OW-1:0] from);
        logic [OW:0]   res;
        logic [OW-1:0] idx_w;
        int            idx;
        res = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx   = (int'(from) + i) % NUM_MASTERS;
            idx_w = OW'(idx);
            if (r[idx_w]) begin
                res = {1'b1, idx_w};
            end
        end
        return res;
    endfunction

    assign req       = ~bus.req_n;
    assign bus_idle  = bus.frame_n & bus.irdy_n;
    assign own_oh    = NUM_MASTERS'(1) << owner_q;
    assign owner_req = req[owner_q];
    assign win_any   = rr_pick(req, last_q);
    assign win_oth   = rr_pick(req & ~own_oh, last_q);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = '0;
        timeout_d = 1'b0;

        case (state_q)
            ST_NOGNT: begin
                if (win_any[OW]) begin
                    state_d = ST_GRANT;
                    owner_d = win_any[OW-1:0];
                    last_d  = win_any[OW-1:0];
                end
`ifdef PCI_ARB_PARK_EN
                else begin
                    state_d = ST_PARK;
                    owner_d = last_q;
                end
`endif
            end
            ST_GRANT: begin
                if (!bus.frame_n) begin
                    state_d = ST_BUSY;
                end else if (!owner_req && bus_idle) begin
                    state_d = ST_GAP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = ST_GAP;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BUSY: begin
                // Idle check first so an idle-bus handover always goes through GAP.
                if (bus_idle) begin
                    state_d = ST_GRANT;
                end else if (win_oth[OW]) begin
                    owner_d = win_oth[OW-1:0];
                    last_d  = win_oth[OW-1:0];
                end
            end
            ST_GAP: begin
                if (win_any[OW]) begin
                    state_d = ST_GRANT;
                    owner_d = win_any[OW-1:0];
                    last_d  = win_any[OW-1:0];
                end else begin
                    state_d = ST_NOGNT;
                end
            end
            ST_PARK: begin
`ifdef PCI_ARB_PARK_EN
                if (!bus.frame_n) begin
                    state_d = ST_BUSY;
                end else if (owner_req) begin
                    state_d = ST_GRANT;
                end else if (|req) begin
                    state_d = ST_GAP;
                end
`else
                state_d = ST_NOGNT;
`endif
            end
            default: state_d = ST_NOGNT;
        endcase

        owner_valid_d = (state_d == ST_GRANT) || (state_d == ST_BUSY) || (state_d == ST_PARK);
        gnt_n_d       = owner_valid_d ? ~(NUM_MASTERS'(1) << owner_d) : '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_NOGNT;
            gnt_n_q       <= '1;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            last_q        <= OW'(NUM_MASTERS - 1);
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            gnt_n_q       <= gnt_n_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            timeout_q     <= timeout_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.gnt_n       = gnt_n_q;
    assign bus.owner       = owner_q;
    assign bus.owner_valid = owner_valid_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_pci_arbiter.sv
// Self-checking bench for pci_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_pci_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    pci_arbiter_if #(.NUM_MASTERS(N)) bus ();

    pci_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who holds the grant (-1 none) and what phase that holder is in.
    typedef struct packed {
        int holder;
        bit txn;
        bit parked;
        bit gap;
        int idle;
        int last;
        int owner;
        bit to;
    } model_t;

    model_t m;

    function automatic int rr_next(int last, logic [N-1:0] req, int excl);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (req[j] && j != excl) return j;
        end
        return -1;
    endfunction

    function automatic model_t model_next(model_t s, logic r, logic [N-1:0] req,
                                          logic fn, logic in_n);
        model_t n;
        int     w;
        bit     idle_bus;
        n    = s;
        n.to = 1'b0;
        if (r) begin
            n.holder = -1; n.txn = 0; n.parked = 0; n.gap = 0;
            n.idle = 0; n.last = N - 1; n.owner = 0;
            return n;
        end
        idle_bus = fn && in_n;
        if (s.holder < 0) begin
            w     = rr_next(s.last, req, -1);
            n.gap = 0;
            if (w >= 0) begin
                n.holder = w; n.last = w; n.owner = w; n.idle = 0; n.txn = 0;
            end
`ifdef PCI_ARB_PARK_EN
            else if (!s.gap) begin
                n.holder = s.last; n.owner = s.last; n.parked = 1;
            end
`endif
        end else if (s.parked) begin
            if (!fn) begin
                n.parked = 0; n.txn = 1;
            end else if (req[s.holder]) begin
                n.parked = 0; n.idle = 0;
            end else if (req != '0) begin
                n.parked = 0; n.holder = -1; n.gap = 1;
            end
        end else if (s.txn) begin
            if (idle_bus) begin
                n.txn = 0; n.idle = 0;
            end else begin
                w = rr_next(s.last, req, s.holder);
                if (w >= 0) begin
                    n.holder = w; n.last = w; n.owner = w;
                end
            end
        end else begin
            if (!fn) begin
                n.txn = 1;
            end else if (!req[s.holder] && idle_bus) begin
                n.holder = -1; n.gap = 1;
            end else if (s.idle == TO - 1) begin
                n.holder = -1; n.gap = 1; n.to = 1;
            end else begin
                n.idle = s.idle + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m, rst, ~bus.req_n, bus.frame_n, bus.irdy_n);

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.req_n   = '1;
        bus.frame_n = 1'b1;
        bus.irdy_n  = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.gnt_n !== 4'b1111) begin errors++; $display("FAIL reset_gnt got=%b exp=%b", bus.gnt_n, 4'b1111); end
        checks++; if (bus.owner !== 2'd0) begin errors++; $display("FAIL reset_owner got=%0d exp=0", bus.owner); end
        checks++; if (bus.owner_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.owner_valid); end
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", bus.timeout); end
        cyc();
`ifdef PCI_ARB_PARK_EN
        checks++; if (bus.gnt_n !== 4'b0111) begin errors++; $display("FAIL reset_park gnt got=%b exp=%b", bus.gnt_n, 4'b0111); end
`else
        checks++; if (bus.gnt_n !== 4'b1111) begin errors++; $display("FAIL reset_idle gnt got=%b exp=%b", bus.gnt_n, 4'b1111); end
`endif
    endtask

    task automatic test_rotation();
        logic [3:0] exp;
        do_reset();
        bus.req_n = 4'b0000;
        cyc();
        checks++; if (bus.gnt_n !== 4'b1110) begin errors++; $display("FAIL rot_first gnt got=%b exp=%b", bus.gnt_n, 4'b1110); end
        for (int k = 0; k < N; k++) begin
            int nxt;
            nxt            = (k + 1) % N;
            bus.req_n[k]   = 1'b1;
            bus.frame_n    = 1'b0;
            bus.irdy_n     = 1'b0;
            cyc();
            exp = ~(4'b0001 << k);
            checks++; if (bus.gnt_n !== exp) begin errors++; $display("FAIL rot_busy%0d gnt got=%b exp=%b", k, bus.gnt_n, exp); end
            bus.frame_n = 1'b1;
            bus.irdy_n  = 1'b1;
            cyc();
            checks++; if (bus.gnt_n !== exp) begin errors++; $display("FAIL rot_held%0d gnt got=%b exp=%b", k, bus.gnt_n, exp); end
            cyc();
            checks++; if (bus.gnt_n !== 4'b1111) begin errors++; $display("FAIL rot_gap%0d gnt got=%b exp=%b", k, bus.gnt_n, 4'b1111); end
            bus.req_n[k] = 1'b0;
            cyc();
            exp = ~(4'b0001 << nxt);
            checks++; if (bus.gnt_n !== exp) begin errors++; $display("FAIL rot_next%0d gnt got=%b exp=%b", nxt, bus.gnt_n, exp); end
        end
    endtask

    task automatic test_timeout();
        int lowcnt;
        do_reset();
        bus.req_n = 4'b1011;
        cyc();
        lowcnt = 0;
        while (bus.gnt_n[2] === 1'b0 && lowcnt < 40) begin
            lowcnt++;
            cyc();
        end
        checks++; if (lowcnt != TO) begin errors++; $display("FAIL to_hold cycles got=%0d exp=%0d", lowcnt, TO); end
        checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got=%b exp=1", bus.timeout); end
        checks++; if (bus.gnt_n !== 4'b1111) begin errors++; $display("FAIL to_release gnt got=%b exp=%b", bus.gnt_n, 4'b1111); end
        cyc();
        checks++; if (bus.gnt_n !== 4'b1011) begin errors++; $display("FAIL to_regrant gnt got=%b exp=%b", bus.gnt_n, 4'b1011); end
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_end got=%b exp=0", bus.timeout); end
    endtask

    task automatic test_hidden();
        do_reset();
        bus.req_n = 4'b1101;
        cyc();
        checks++; if (bus.gnt_n !== 4'b1101) begin errors++; $display("FAIL hid_grant1 gnt got=%b exp=%b", bus.gnt_n, 4'b1101); end
        bus.frame_n = 1'b0;
        bus.irdy_n  = 1'b0;
        cyc();
        checks++; if (bus.gnt_n !== 4'b1101) begin errors++; $display("FAIL hid_busy gnt got=%b exp=%b", bus.gnt_n, 4'b1101); end
        bus.req_n = 4'b0101;
        cyc();
        checks++; if (bus.gnt_n !== 4'b0111) begin errors++; $display("FAIL hid_move gnt got=%b exp=%b", bus.gnt_n, 4'b0111); end
        checks++; if (bus.owner !== 2'd3) begin errors++; $display("FAIL hid_owner got=%0d exp=3", bus.owner); end
        checks++; if (bus.owner_valid !== 1'b1) begin errors++; $display("FAIL hid_valid got=%b exp=1", bus.owner_valid); end
    endtask

    task automatic test_frame_at_limit();
        do_reset();
        bus.req_n = 4'b1110;
        cyc();
        for (int i = 0; i < TO - 1; i++) cyc();
        checks++; if (bus.gnt_n !== 4'b1110) begin errors++; $display("FAIL lim_hold gnt got=%b exp=%b", bus.gnt_n, 4'b1110); end
        bus.frame_n = 1'b0;
        cyc();
        checks++; if (bus.gnt_n !== 4'b1110) begin errors++; $display("FAIL lim_busy gnt got=%b exp=%b", bus.gnt_n, 4'b1110); end
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL lim_no_timeout got=%b exp=0", bus.timeout); end
        bus.frame_n = 1'b1;
        cyc();
        checks++; if (bus.gnt_n !== 4'b1110) begin errors++; $display("FAIL lim_after gnt got=%b exp=%b", bus.gnt_n, 4'b1110); end
    endtask

    task automatic test_park();
        do_reset();
        bus.req_n = 4'b1011;
        cyc();
        bus.req_n   = 4'b1111;
        bus.frame_n = 1'b0;
        bus.irdy_n  = 1'b0;
        cyc();
        bus.frame_n = 1'b1;
        bus.irdy_n  = 1'b1;
        cyc();
        cyc();
        checks++; if (bus.gnt_n !== 4'b1111) begin errors++; $display("FAIL park_gap gnt got=%b exp=%b", bus.gnt_n, 4'b1111); end
        cyc();
        cyc();
`ifdef PCI_ARB_PARK_EN
        checks++; if (bus.gnt_n !== 4'b1011) begin errors++; $display("FAIL park_hold gnt got=%b exp=%b", bus.gnt_n, 4'b1011); end
        checks++; if (bus.owner_valid !== 1'b1) begin errors++; $display("FAIL park_valid got=%b exp=1", bus.owner_valid); end
        bus.req_n = 4'b1101;
        cyc();
        checks++; if (bus.gnt_n !== 4'b1111) begin errors++; $display("FAIL park_leave gnt got=%b exp=%b", bus.gnt_n, 4'b1111); end
        cyc();
`else
        checks++; if (bus.gnt_n !== 4'b1111) begin errors++; $display("FAIL nopark_idle gnt got=%b exp=%b", bus.gnt_n, 4'b1111); end
        checks++; if (bus.owner_valid !== 1'b0) begin errors++; $display("FAIL nopark_valid got=%b exp=0", bus.owner_valid); end
        bus.req_n = 4'b1101;
        cyc();
`endif
        checks++; if (bus.gnt_n !== 4'b1101) begin errors++; $display("FAIL park_new gnt got=%b exp=%b", bus.gnt_n, 4'b1101); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req_n = 4'b0111;
        cyc();
        bus.frame_n = 1'b0;
        bus.irdy_n  = 1'b0;
        cyc();
        checks++; if (bus.gnt_n !== 4'b0111) begin errors++; $display("FAIL rmid_busy gnt got=%b exp=%b", bus.gnt_n, 4'b0111); end
        rst = 1'b1;
        cyc();
        checks++; if (bus.gnt_n !== 4'b1111) begin errors++; $display("FAIL rmid_release gnt got=%b exp=%b", bus.gnt_n, 4'b1111); end
        checks++; if (bus.owner_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", bus.owner_valid); end
        rst         = 1'b0;
        bus.frame_n = 1'b1;
        bus.irdy_n  = 1'b1;
        bus.req_n   = 4'b0110;
        cyc();
        checks++; if (bus.gnt_n !== 4'b1110) begin errors++; $display("FAIL rmid_first gnt got=%b exp=%b", bus.gnt_n, 4'b1110); end
    endtask

    task automatic test_random();
        logic [N-1:0] rq;
        logic [3:0]   exp_gnt;
        bit           quiet;
        do_reset();
        rq    = '0;
        quiet = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            exp_gnt = (m.holder >= 0) ? ~(4'b0001 << m.holder) : 4'b1111;
            checks++; if (bus.gnt_n !== exp_gnt) begin errors++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, bus.gnt_n, exp_gnt); end
            checks++; if (bus.owner_valid !== (m.holder >= 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, bus.owner_valid, (m.holder >= 0)); end
            checks++; if (bus.timeout !== m.to) begin errors++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", c, bus.timeout, m.to); end
            if (m.holder >= 0) begin
                checks++; if (int'(bus.owner) != m.owner) begin errors++; $display("FAIL rnd_owner cyc=%0d got=%0d exp=%0d", c, bus.owner, m.owner); end
            end
            checks++; if ($countones(~bus.gnt_n) > 1) begin errors++; $display("FAIL rnd_onehot cyc=%0d got=%b exp=at most one low", c, bus.gnt_n); end
            if (c % 64 == 0) quiet = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) rq[i] = ~rq[i];
            end
            bus.req_n   = ~rq;
            bus.frame_n = ($urandom_range(0, quiet ? 49 : 2) != 0);
            bus.irdy_n  = ($urandom_range(0, quiet ? 49 : 2) != 0);
            rst         = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rotation();
        test_timeout();
        test_hidden();
        test_frame_at_limit();
        test_park();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
